sync_filter_bank: RTL and testbench

- Multi-channel input conditioner for asynchronous pins and slow cross-domain levels, operating entirely in the destination clock domain.
- Per channel: a LEVELS-deep synchroniser, a glitch filter (stability counter), registered rise/fall pulse detection, and a sticky event flag with edge-mode select and software clear.
- Generalises the team's 2-flop synchroniser and edge detector into one parametrised bank for GPIO, interrupt and handshake inputs.

---
 rtl/sync_filter_pkg.sv | 12 +
 rtl/sync_filter_ch.sv | 95 +++++++++
 rtl/sync_filter_bank.sv | 42 ++++
 tb/tb_sync_filter_bank.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_filter_pkg.sv
// Shared types for the synchroniser / glitch-filter bank.
package sync_filter_pkg;

   // Per-channel event capture mode, as presented on mode_i[2c+1:2c].
   typedef enum logic [1:0] {
      EDGE_NONE = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_mode_e;

endpackage : sync_filter_pkg

// File: rtl/sync_filter_ch.sv
// One input channel: multi-flop synchroniser, stability-count glitch filter,
// registered rise/fall pulses and a sticky, software-clearable event flag.
module sync_filter_ch
   import sync_filter_pkg::*;
#(
   parameter int unsigned LEVELS        = 2,
   parameter int unsigned FILTER_CYCLES = 4,
   parameter logic        RESET_BIT     = 1'b0
) (
   input  logic       clk_i,
   input  logic       arst_ni,
   input  logic       async_i,
   input  logic [1:0] mode_i,
   input  logic       clr_i,
   output logic       level_o,
   output logic       rise_o,
   output logic       fall_o,
   output logic       event_o
);

   // A single-cycle filter still needs a 1-bit counter to keep the logic uniform.
   localparam int unsigned     CNT_W   = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

   logic [LEVELS-1:0] stage_q, stage_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              level_q, level_d;
   logic              rise_q, rise_d;
   logic              fall_q, fall_d;
   logic              event_q, event_d;
   logic              sync;
   logic              hit;
   edge_mode_e        mode;

   assign mode = edge_mode_e'(mode_i);
   assign sync = stage_q[LEVELS-1];

   // Plain shift chain; nothing may sit between synchroniser flops.
   always_comb begin
      stage_d = {stage_q[LEVELS-2:0], async_i};
   end

   // Level follows sync only after FILTER_CYCLES consecutive mismatching cycles.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (sync == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         level_d = sync;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      rise_d = ~level_q &  level_d;
      fall_d =  level_q & ~level_d;
   end

   // Sticky event: a new hit takes priority over a simultaneous clear.
   always_comb begin
      hit = 1'b0;
      case (mode)
         EDGE_RISE: hit = rise_d;
         EDGE_FALL: hit = fall_d;
         EDGE_BOTH: hit = rise_d | fall_d;
         default:   hit = 1'b0;
      endcase
      event_d = hit | (event_q & ~clr_i);
   end

   // State registers; reset leaves no edge pending on release.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         stage_q <= {LEVELS{RESET_BIT}};
         cnt_q   <= '0;
         level_q <= RESET_BIT;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         event_q <= 1'b0;
      end else begin
         stage_q <= stage_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         event_q <= event_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;
   assign event_o = event_q;

endmodule : sync_filter_ch

// File: rtl/sync_filter_bank.sv
// Bank of independent synchronise/filter/edge-detect channels.
module sync_filter_bank #(
   parameter int unsigned          CHANNELS      = 4,
   parameter int unsigned          LEVELS        = 2,
   parameter int unsigned          FILTER_CYCLES = 4,
   parameter logic [CHANNELS-1:0]  RESET_VAL     = '0
) (
   input  logic                    clk_i,
   input  logic                    arst_ni,
   input  logic [CHANNELS-1:0]     async_i,
   input  logic [2*CHANNELS-1:0]   mode_i,
   input  logic [CHANNELS-1:0]     clr_i,
   output logic [CHANNELS-1:0]     level_o,
   output logic [CHANNELS-1:0]     rise_o,
   output logic [CHANNELS-1:0]     fall_o,
   output logic [CHANNELS-1:0]     event_o,
   output logic                    event_any_o
);

   // One channel instance per input bit; channels share nothing but the clock/reset.
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      sync_filter_ch #(
         .LEVELS        (LEVELS),
         .FILTER_CYCLES (FILTER_CYCLES),
         .RESET_BIT     (RESET_VAL[c])
      ) u_ch (
         .clk_i   (clk_i),
         .arst_ni (arst_ni),
         .async_i (async_i[c]),
         .mode_i  (mode_i[2*c +: 2]),
         .clr_i   (clr_i[c]),
         .level_o (level_o[c]),
         .rise_o  (rise_o[c]),
         .fall_o  (fall_o[c]),
         .event_o (event_o[c])
      );
   end

   // Summary interrupt: combinational OR of the registered flags.
   assign event_any_o = |event_o;

endmodule : sync_filter_bank

// File: tb/tb_sync_filter_bank.sv
// Directed bench for sync_filter_bank with a window-based reference model.
module tb_sync_filter_bank;

   localparam int         CH = 4;
   localparam int         LV = 2;
   localparam int         FC = 4;
   localparam logic [3:0] RV = 4'b0101;

   logic          clk;
   logic          arst_ni;
   logic [CH-1:0] async_i;
   logic [2*CH-1:0] mode_i;
   logic [CH-1:0] clr_i;
   logic [CH-1:0] level_o, rise_o, fall_o, event_o;
   logic          event_any_o;

   int n_tests = 0;
   int n_fail  = 0;

   sync_filter_bank #(
      .CHANNELS      (CH),
      .LEVELS        (LV),
      .FILTER_CYCLES (FC),
      .RESET_VAL     (RV)
   ) dut (
      .clk_i       (clk),
      .arst_ni     (arst_ni),
      .async_i     (async_i),
      .mode_i      (mode_i),
      .clr_i       (clr_i),
      .level_o     (level_o),
      .rise_o      (rise_o),
      .fall_o      (fall_o),
      .event_o     (event_o),
      .event_any_o (event_any_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: history of raw samples gives sync; the level flips when the
   // last FC sync samples all disagree with it.
   logic [CH-1:0] a_hist[$];
   logic [CH-1:0] s_hist[$];
   logic [CH-1:0] m_level, m_rise, m_fall, m_event;

   task automatic model_reset();
      a_hist.delete();
      s_hist.delete();
      repeat (LV) a_hist.push_back(RV);
      repeat (FC) s_hist.push_back(RV);
      m_level = RV;
      m_rise  = '0;
      m_fall  = '0;
      m_event = '0;
   endtask

   initial begin : model
      logic [CH-1:0] s, nl;
      logic [1:0]    md;
      bit            all_diff;
      model_reset();
      forever begin
         @(posedge clk or negedge arst_ni);
         if (!arst_ni) begin
            model_reset();
         end else begin
            s = a_hist[LV-1];
            a_hist.push_front(async_i);
            void'(a_hist.pop_back());
            s_hist.push_front(s);
            void'(s_hist.pop_back());
            for (int c = 0; c < CH; c++) begin
               all_diff = 1'b1;
               for (int k = 0; k < FC; k++)
                  if (s_hist[k][c] == m_level[c]) all_diff = 1'b0;
               nl[c] = all_diff ? ~m_level[c] : m_level[c];
            end
            m_rise = nl & ~m_level;
            m_fall = ~nl & m_level;
            for (int c = 0; c < CH; c++) begin
               md = mode_i[2*c +: 2];
               m_event[c] = (md[0] & m_rise[c]) | (md[1] & m_fall[c]) | (m_event[c] & ~clr_i[c]);
            end
            m_level = nl;
         end
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("cmp_level", 32'(level_o), 32'(m_level));
      check("cmp_rise",  32'(rise_o),  32'(m_rise));
      check("cmp_fall",  32'(fall_o),  32'(m_fall));
      check("cmp_event", 32'(event_o), 32'(m_event));
      check("cmp_any",   32'(event_any_o), 32'(|m_event));
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int r_cnt, f_cnt, p_cnt;

   initial begin
      arst_ni = 1'b1;
      async_i = RV;
      mode_i  = '0;
      clr_i   = '0;
      #1 arst_ni = 1'b0;

      // Reset state
      tick(2);
      check("rst_level", 32'(level_o), 32'h5);
      check("rst_rise",  32'(rise_o),  32'h0);
      check("rst_event", 32'(event_o), 32'h0);
      check("rst_any",   32'(event_any_o), 32'h0);
      arst_ni = 1'b1;
      p_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if ((rise_o | fall_o | event_o) != '0) p_cnt++;
      end
      check("rel_quiet", 32'(p_cnt), 32'h0);
      check("rel_level", 32'(level_o), 32'h5);

      // Bring all channels low with mode NONE: falls occur but no event
      async_i = 4'b0000;
      tick(10);
      check("prep_level", 32'(level_o), 32'h0);
      check("prep_event", 32'(event_o), 32'h0);

      // Ch0 rise with mode RISE; level changes at edge 5
      mode_i[1:0] = 2'b01;
      async_i[0]  = 1'b1;
      tick(5);
      check("ch0_lvl_e4", 32'(level_o[0]), 32'h0);
      tick(1);
      check("ch0_lvl_e5", 32'(level_o[0]), 32'h1);
      check("ch0_rise",   32'(rise_o[0]),  32'h1);
      check("ch0_event",  32'(event_o[0]), 32'h1);
      check("ch0_any",    32'(event_any_o), 32'h1);
      tick(1);
      check("ch0_rise_1cyc", 32'(rise_o[0]), 32'h0);
      check("ch0_event_sticky", 32'(event_o[0]), 32'h1);

      // Ch1 3-cycle glitch is rejected
      async_i[1] = 1'b1;
      tick(3);
      async_i[1] = 1'b0;
      p_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (level_o[1] | rise_o[1] | fall_o[1]) p_cnt++;
      end
      check("ch1_glitch", 32'(p_cnt), 32'h0);

      // Ch1 4-cycle pulse passes: high at edge 5, low again at edge 9
      async_i[1] = 1'b1;
      tick(4);
      async_i[1] = 1'b0;
      tick(1);
      check("ch1_lvl_e4", 32'(level_o[1]), 32'h0);
      tick(1);
      check("ch1_lvl_e5", 32'(level_o[1]), 32'h1);
      check("ch1_rise",   32'(rise_o[1]),  32'h1);
      tick(4);
      check("ch1_lvl_e9", 32'(level_o[1]), 32'h0);
      check("ch1_fall",   32'(fall_o[1]),  32'h1);
      check("ch1_event",  32'(event_o[1]), 32'h0);

      // Ch2 mode BOTH: one rise, one fall, flag held until cleared
      mode_i[5:4] = 2'b11;
      async_i[2]  = 1'b1;
      r_cnt = 0; f_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         r_cnt += int'(rise_o[2]);
         f_cnt += int'(fall_o[2]);
      end
      check("ch2_rise_cnt", 32'(r_cnt), 32'h1);
      check("ch2_event_r",  32'(event_o[2]), 32'h1);
      async_i[2] = 1'b0;
      r_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         r_cnt += int'(rise_o[2]);
         f_cnt += int'(fall_o[2]);
      end
      check("ch2_fall_cnt", 32'(f_cnt), 32'h1);
      check("ch2_rise_cnt2", 32'(r_cnt), 32'h0);
      check("ch2_event_f",  32'(event_o[2]), 32'h1);
      clr_i[2] = 1'b1;
      tick(1);
      clr_i[2] = 1'b0;
      check("ch2_cleared", 32'(event_o[2]), 32'h0);

      // Ch3 mode FALL: clear coincident with the hit loses; next-cycle clear wins
      async_i[3] = 1'b1;
      tick(10);
      check("ch3_high", 32'(level_o[3]), 32'h1);
      mode_i[7:6] = 2'b10;
      async_i[3]  = 1'b0;
      tick(5);
      clr_i[3] = 1'b1;
      tick(1);
      check("ch3_fall",       32'(fall_o[3]),  32'h1);
      check("ch3_set_wins",   32'(event_o[3]), 32'h1);
      tick(1);
      clr_i[3] = 1'b0;
      check("ch3_clr_after",  32'(event_o[3]), 32'h0);

      // Async reset mid-count on ch0 (cnt=2 after edge 3)
      async_i[0] = 1'b0;
      tick(4);
      check("pre_rst_event", 32'(event_o[0]), 32'h1);
      arst_ni = 1'b0;
      #1;
      check("mid_rst_level", 32'(level_o), 32'h5);
      check("mid_rst_edges", 32'(rise_o | fall_o), 32'h0);
      check("mid_rst_event", 32'(event_o), 32'h0);
      check("mid_rst_any",   32'(event_any_o), 32'h0);
      tick(2);
      arst_ni = 1'b1;
      tick(5);
      check("post_rst_e4", 32'(level_o[0]), 32'h1);
      tick(1);
      check("post_rst_e5", 32'(level_o[0]), 32'h0);
      check("post_rst_fall", 32'(fall_o[0]), 32'h1);
      tick(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_sync_filter_bank
